// File: rtl/audvid_pkg.sv
// Shared types and constants for the SD card read scheduler:
// FSM state encoding, block geometry and byte-counter width.
package audvid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_READY,
    ST_TILE_REQ,
    ST_TILE_XFER,
    ST_AUD_CHECK,
    ST_AUD_REQ,
    ST_AUD_XFER
  } sched_state_t;

  localparam int BLOCK_BYTES = 512;
  localparam int BYTE_CNT_W  = 9;

  function automatic logic is_xfer(input sched_state_t s);
    return (s == ST_TILE_XFER) || (s == ST_AUD_XFER);
  endfunction

  function automatic logic is_req(input sched_state_t s);
    return (s == ST_TILE_REQ) || (s == ST_AUD_REQ);
  endfunction

endpackage

// File: rtl/sd_read_scheduler_if.sv
// Block-request / byte-stream handshake between the scheduler (master)
// and the SD card controller (slave).
interface sd_read_scheduler_if;

  logic        SD_Ready;
  logic        SD_BlockReq;
  logic [15:0] SD_BlockAddr;
  logic        SD_BlockAck;
  logic        SD_ByteValid;
  logic [7:0]  SD_Byte;

  modport master (
    input  SD_Ready,
    output SD_BlockReq,
    output SD_BlockAddr,
    input  SD_BlockAck,
    input  SD_ByteValid,
    input  SD_Byte
  );

  modport slave (
    output SD_Ready,
    input  SD_BlockReq,
    input  SD_BlockAddr,
    output SD_BlockAck,
    output SD_ByteValid,
    output SD_Byte
  );

endinterface

// File: rtl/sd_block_counter.sv
// Byte position within the current 512-byte SD block; last flags the
// final byte so the scheduler can close the block on that strobe.
module sd_block_counter
  import audvid_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  inc,
    output logic [BYTE_CNT_W-1:0] cnt,
    output logic                  last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == BYTE_CNT_W'(BLOCK_BYTES - 1));

endmodule

// File: rtl/sd_read_scheduler.sv
// Schedules SD block reads: loads the tile image once (or on Reload) and
// otherwise keeps the audio FIFO topped up one block at a time.
module sd_read_scheduler
  import audvid_pkg::*;
#(
    parameter logic [15:0] TILE_BASE    = 16'h0000,
    parameter int          TILE_BLOCKS  = 16,
    parameter logic [15:0] AUDIO_BASE   = 16'h0010,
    parameter int          AUDIO_BLOCKS = 1024,
    parameter int          AUDIO_LOW    = 512
) (
    input  logic                       MasterCLK,
    input  logic                       Reset,
    input  logic                       Start,
    input  logic                       Reload,
    sd_read_scheduler_if.master        sd,
    output logic                       Tile_WrEn,
    output logic [12:0]                Tile_WrAddr,
    output logic [7:0]                 Tile_WrData,
    input  logic [10:0]                Audio_Level,
    output logic                       Audio_WrEn,
    output logic [7:0]                 Audio_WrData,
    output logic                       Busy,
    output logic                       TilesLoaded
);

    sched_state_t          state;
    logic                  tile_pend;
    logic [15:0]           tile_blk;
    logic [15:0]           aud_blk;
    logic                  blk_req;
    logic [15:0]           blk_addr;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic                  byte_last;
    logic                  cnt_clr;
    logic                  byte_in;
    logic                  level_low;

    assign sd.SD_BlockReq  = blk_req;
    assign sd.SD_BlockAddr = blk_addr;

    // Counter restarts when a request is acknowledged or the card drops out.
    assign cnt_clr   = ((state != ST_IDLE) && !sd.SD_Ready) ||
                       (is_req(state) && sd.SD_BlockAck);
    assign byte_in   = sd.SD_Ready && sd.SD_ByteValid && is_xfer(state);
    assign level_low = (32'(Audio_Level) <= 32'(AUDIO_LOW));

    sd_block_counter u_byte_cnt (
        .clk   (MasterCLK),
        .rst_n (Reset),
        .clr   (cnt_clr),
        .inc   (byte_in),
        .cnt   (byte_cnt),
        .last  (byte_last)
    );

    always_ff @(posedge MasterCLK or negedge Reset) begin
        if (!Reset) begin
            state        <= ST_IDLE;
            tile_pend    <= 1'b1;
            tile_blk     <= '0;
            aud_blk      <= '0;
            blk_req      <= 1'b0;
            blk_addr     <= '0;
            Tile_WrEn    <= 1'b0;
            Tile_WrAddr  <= '0;
            Tile_WrData  <= '0;
            Audio_WrEn   <= 1'b0;
            Audio_WrData <= '0;
            Busy         <= 1'b0;
            TilesLoaded  <= 1'b0;
        end else begin
            Tile_WrEn  <= 1'b0;
            Audio_WrEn <= 1'b0;
            if (state == ST_IDLE) begin
                if (Start) begin
                    state <= ST_WAIT_READY;
                    Busy  <= 1'b1;
                end
            end else if (!sd.SD_Ready) begin
                // Interrupted block is re-requested from byte 0 on recovery.
                state   <= ST_WAIT_READY;
                blk_req <= 1'b0;
            end else begin
                case (state)
                    ST_WAIT_READY: begin
                        if (tile_pend) begin
                            state    <= ST_TILE_REQ;
                            blk_req  <= 1'b1;
                            blk_addr <= TILE_BASE + tile_blk;
                        end else begin
                            state <= ST_AUD_CHECK;
                        end
                    end
                    ST_TILE_REQ: begin
                        if (sd.SD_BlockAck) begin
                            blk_req <= 1'b0;
                            state   <= ST_TILE_XFER;
                        end
                    end
                    ST_TILE_XFER: begin
                        if (byte_in) begin
                            Tile_WrEn   <= 1'b1;
                            Tile_WrAddr <= {tile_blk[3:0], byte_cnt};
                            Tile_WrData <= sd.SD_Byte;
                            if (byte_last) begin
                                if (tile_blk == 16'(TILE_BLOCKS - 1)) begin
                                    TilesLoaded <= 1'b1;
                                    tile_blk    <= '0;
                                    tile_pend   <= 1'b0;
                                    state       <= ST_AUD_CHECK;
                                end else begin
                                    tile_blk <= tile_blk + 16'd1;
                                    state    <= ST_TILE_REQ;
                                    blk_req  <= 1'b1;
                                    blk_addr <= TILE_BASE + tile_blk + 16'd1;
                                end
                            end
                        end
                    end
                    ST_AUD_CHECK: begin
                        if (tile_pend) begin
                            TilesLoaded <= 1'b0;
                            state       <= ST_TILE_REQ;
                            blk_req     <= 1'b1;
                            blk_addr    <= TILE_BASE + tile_blk;
                        end else if (level_low) begin
                            state    <= ST_AUD_REQ;
                            blk_req  <= 1'b1;
                            blk_addr <= AUDIO_BASE + aud_blk;
                        end
                    end
                    ST_AUD_REQ: begin
                        if (sd.SD_BlockAck) begin
                            blk_req <= 1'b0;
                            state   <= ST_AUD_XFER;
                        end
                    end
                    ST_AUD_XFER: begin
                        if (byte_in) begin
                            Audio_WrEn   <= 1'b1;
                            Audio_WrData <= sd.SD_Byte;
                            if (byte_last) begin
                                aud_blk <= (aud_blk == 16'(AUDIO_BLOCKS - 1)) ?
                                           16'd0 : aud_blk + 16'd1;
                                state   <= ST_AUD_CHECK;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
            // A Reload arriving with the final tile byte must survive the clear.
            if (Reload && (state != ST_IDLE)) begin
                tile_pend <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sd_read_scheduler.sv
// Directed bench for sd_read_scheduler: a card model serves blocks, a
// scoreboard predicts every tile/audio write and checks them in order.
module tb_sd_read_scheduler;

    logic        MasterCLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic        Reload;
    logic        Tile_WrEn;
    logic [12:0] Tile_WrAddr;
    logic [7:0]  Tile_WrData;
    logic [10:0] Audio_Level;
    logic        Audio_WrEn;
    logic [7:0]  Audio_WrData;
    logic        Busy;
    logic        TilesLoaded;

    sd_read_scheduler_if sdif ();

    sd_read_scheduler dut (
        .MasterCLK    (MasterCLK),
        .Reset        (Reset),
        .Start        (Start),
        .Reload       (Reload),
        .sd           (sdif),
        .Tile_WrEn    (Tile_WrEn),
        .Tile_WrAddr  (Tile_WrAddr),
        .Tile_WrData  (Tile_WrData),
        .Audio_Level  (Audio_Level),
        .Audio_WrEn   (Audio_WrEn),
        .Audio_WrData (Audio_WrData),
        .Busy         (Busy),
        .TilesLoaded  (TilesLoaded)
    );

    always #5 MasterCLK = ~MasterCLK;

    typedef struct packed {
        logic [12:0] a;
        logic [7:0]  d;
    } tile_exp_t;

    tile_exp_t  tile_q[$];
    logic [7:0] aud_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int tile_wr_cnt = 0;
    int aud_wr_cnt = 0;
    int req_cnt = 0;
    logic req_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [15:0] blk, input logic [8:0] idx);
        return (blk[7:0] * 8'd7) + idx[7:0] + {7'd0, idx[8]};
    endfunction

    // Scoreboard pop side: every write strobe must match the next prediction.
    always @(negedge MasterCLK) begin
        tile_exp_t t;
        logic [7:0] d;
        if (Tile_WrEn) begin
            tile_wr_cnt++;
            if (tile_q.size() == 0) begin
                check("tile_unexpected_write", {19'd0, Tile_WrAddr}, 32'hFFFF_FFFF);
            end else begin
                t = tile_q.pop_front();
                check("tile_addr", {19'd0, Tile_WrAddr}, {19'd0, t.a});
                check("tile_data", {24'd0, Tile_WrData}, {24'd0, t.d});
            end
        end
        if (Audio_WrEn) begin
            aud_wr_cnt++;
            if (aud_q.size() == 0) begin
                check("aud_unexpected_write", {24'd0, Audio_WrData}, 32'hFFFF_FFFF);
            end else begin
                d = aud_q.pop_front();
                check("aud_data", {24'd0, Audio_WrData}, {24'd0, d});
            end
        end
        if (sdif.SD_BlockReq && !req_prev) req_cnt++;
        req_prev = sdif.SD_BlockReq;
    end

    task automatic wait_req(input string tag, input logic [15:0] exp_addr);
        int k;
        for (k = 0; k < 400 && !sdif.SD_BlockReq; k++) @(negedge MasterCLK);
        check({tag, "_req_seen"}, {31'd0, sdif.SD_BlockReq}, 32'd1);
        check({tag, "_req_addr"}, {16'd0, sdif.SD_BlockAddr}, {16'd0, exp_addr});
    endtask

    // Acknowledge the pending request and stream nbytes of block blk.
    task automatic serve(input logic [15:0] blk, input bit is_tile, input int nbytes,
                         input int reload_at);
        tile_exp_t t;
        sdif.SD_BlockAck = 1'b1;
        @(negedge MasterCLK);
        sdif.SD_BlockAck = 1'b0;
        check("req_dropped_after_ack", {31'd0, sdif.SD_BlockReq}, 32'd0);
        for (int i = 0; i < nbytes; i++) begin
            sdif.SD_ByteValid = 1'b1;
            sdif.SD_Byte      = byte_of(blk, 9'(i));
            Reload            = (i == reload_at);
            if (is_tile) begin
                t.a = {blk[3:0], 9'(i)};
                t.d = sdif.SD_Byte;
                tile_q.push_back(t);
            end else begin
                aud_q.push_back(sdif.SD_Byte);
            end
            @(negedge MasterCLK);
        end
        sdif.SD_ByteValid = 1'b0;
        Reload            = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},      {31'd0, sdif.SD_BlockReq}, 32'd0);
        check({tag, "_addr"},     {16'd0, sdif.SD_BlockAddr}, 32'd0);
        check({tag, "_twen"},     {31'd0, Tile_WrEn}, 32'd0);
        check({tag, "_twaddr"},   {19'd0, Tile_WrAddr}, 32'd0);
        check({tag, "_twdata"},   {24'd0, Tile_WrData}, 32'd0);
        check({tag, "_awen"},     {31'd0, Audio_WrEn}, 32'd0);
        check({tag, "_awdata"},   {24'd0, Audio_WrData}, 32'd0);
        check({tag, "_busy"},     {31'd0, Busy}, 32'd0);
        check({tag, "_loaded"},   {31'd0, TilesLoaded}, 32'd0);
    endtask

    initial begin
        int base;
        Reset = 1'b0; Start = 1'b0; Reload = 1'b0; Audio_Level = 11'd1023;
        sdif.SD_Ready = 1'b1; sdif.SD_BlockAck = 1'b0;
        sdif.SD_ByteValid = 1'b0; sdif.SD_Byte = 8'h00;
        repeat (3) @(negedge MasterCLK);
        check_reset_outputs("rst");

        // Stray inputs in IDLE must do nothing.
        Reset = 1'b1;
        @(negedge MasterCLK);
        Reload = 1'b1; sdif.SD_BlockAck = 1'b1; sdif.SD_ByteValid = 1'b1; sdif.SD_Byte = 8'hA5;
        repeat (3) @(negedge MasterCLK);
        Reload = 1'b0; sdif.SD_BlockAck = 1'b0; sdif.SD_ByteValid = 1'b0;
        @(negedge MasterCLK);
        check_reset_outputs("idle_stray");

        // Full tile image load.
        Start = 1'b1;
        @(negedge MasterCLK);
        Start = 1'b0;
        check("busy_after_start", {31'd0, Busy}, 32'd1);
        for (int b = 0; b < 16; b++) begin
            wait_req("tile", 16'(b));
            serve(16'(b), 1'b1, 512, -1);
        end
        repeat (20) @(negedge MasterCLK);
        check("tiles_loaded", {31'd0, TilesLoaded}, 32'd1);
        check("tile_wr_cnt", tile_wr_cnt, 32'd8192);
        check("tile_req_cnt", req_cnt, 32'd16);
        check("no_audio_req", {31'd0, sdif.SD_BlockReq}, 32'd0);
        check("tile_q_empty", tile_q.size(), 32'd0);

        // Stray bytes in AUD_CHECK are dropped.
        sdif.SD_ByteValid = 1'b1;
        repeat (4) @(negedge MasterCLK);
        sdif.SD_ByteValid = 1'b0;
        @(negedge MasterCLK);
        check("aud_check_stray", aud_wr_cnt, 32'd0);

        // Audio threshold: 513 idles, 512 requests block 16.
        Audio_Level = 11'd513;
        repeat (20) @(negedge MasterCLK);
        check("level513_no_req", req_cnt, 32'd16);
        Audio_Level = 11'd512;
        wait_req("aud0", 16'd16);
        Audio_Level = 11'd1023;
        serve(16'd16, 1'b0, 512, -1);
        repeat (3) @(negedge MasterCLK);
        check("aud0_wr_cnt", aud_wr_cnt, 32'd512);

        // Audio block counter wrap.
        force dut.aud_blk = 16'd1023;
        @(negedge MasterCLK);
        release dut.aud_blk;
        Audio_Level = 11'd0;
        wait_req("aud_last", 16'd1039);
        Audio_Level = 11'd1023;
        serve(16'd1039, 1'b0, 512, -1);
        Audio_Level = 11'd0;
        wait_req("aud_wrap", 16'd16);
        Audio_Level = 11'd1023;
        serve(16'd16, 1'b0, 512, -1);

        // Reload mid audio block: block completes, then tile reload starts.
        Audio_Level = 11'd0;
        wait_req("aud_reload", 16'd17);
        Audio_Level = 11'd1023;
        serve(16'd17, 1'b0, 512, 100);
        wait_req("reload_tile0", 16'd0);
        check("reload_loaded_clr", {31'd0, TilesLoaded}, 32'd0);
        check("reload_aud_cnt", aud_wr_cnt, 32'd2048);
        serve(16'd0, 1'b1, 512, -1);
        for (int b = 1; b < 5; b++) begin
            wait_req("reload_tile", 16'(b));
            serve(16'(b), 1'b1, 512, -1);
        end

        // Card drops out at tile block 5, byte 300.
        wait_req("tile5", 16'd5);
        serve(16'd5, 1'b1, 300, -1);
        sdif.SD_Ready = 1'b0;
        repeat (3) @(negedge MasterCLK);
        check("ready_drop_req", {31'd0, sdif.SD_BlockReq}, 32'd0);
        check("ready_drop_busy", {31'd0, Busy}, 32'd1);
        sdif.SD_Ready = 1'b1;
        base = tile_wr_cnt;
        wait_req("tile5_retry", 16'd5);
        serve(16'd5, 1'b1, 512, -1);
        for (int b = 6; b < 16; b++) begin
            wait_req("reload_tile", 16'(b));
            serve(16'(b), 1'b1, 512, -1);
        end
        repeat (3) @(negedge MasterCLK);
        check("retry_wr_cnt", tile_wr_cnt - base, 32'd5632);
        check("reload_loaded", {31'd0, TilesLoaded}, 32'd1);

        // Reset pulsed mid tile transfer.
        Reload = 1'b1;
        @(negedge MasterCLK);
        Reload = 1'b0;
        wait_req("rst_tile0", 16'd0);
        serve(16'd0, 1'b1, 100, -1);
        sdif.SD_ByteValid = 1'b1;
        #2 Reset = 1'b0;
        repeat (2) @(negedge MasterCLK);
        check_reset_outputs("mid_rst");
        Reset = 1'b1;
        repeat (3) @(negedge MasterCLK);
        sdif.SD_ByteValid = 1'b0;
        check_reset_outputs("post_rst");
        check("final_tile_q", tile_q.size(), 32'd0);
        check("final_aud_q", aud_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
